// File: rtl/data_mem_bank.sv
// data_mem_bank: byte-addressed, big-endian data memory with LATENCY wait states
// and a registered load result.
// Optional feature macro: DATA_MEM_MISALIGN_TRAP_EN. When it is defined, misaligned
// or reserved-size accesses fault. When it is undefined, the low address bits are
// silently aligned and the reserved size is treated as a word access.
module data_mem_bank #(
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clock_enable,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        waitrequest,
    output logic        ack,
    output logic        error
);

    localparam int         AW      = $clog2(DEPTH);
    localparam bit         ZeroLat = (LATENCY == 0);
    localparam logic [2:0] LastCnt = ZeroLat ? 3'd0 : 3'(LATENCY - 1);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    count_q;
    logic [AW-1:0] addr_q;
    logic [1:0]    size_q;
    logic          sext_q;
    logic          isWrite_q;
    logic [31:0]   wdata_q;
    logic [31:0]   readData_q;
    logic          ack_q;
    logic          error_q;
    logic [7:0]    mem_q [DEPTH];

    logic          request;
    logic          accept;
    logic          complete;
    logic [AW-1:0] opAddr;
    logic [1:0]    opSize;
    logic          opSext;
    logic          opWrite;
    logic [31:0]   opWdata;
    logic [1:0]    effSize;
    logic          fault;
    logic [AW-1:0] idx0, idx1, idx2, idx3;
    logic [7:0]    b0, b1, b2, b3;
    logic [31:0]   loadValue;
    logic          commitStore;
    logic          unusedAddrBits;

    // Address bits above the memory size only wrap, so they are deliberately ignored.
    assign unusedAddrBits = ^address[31:AW];

    assign request  = read | write;
    assign accept   = (state_q == IDLE) && clock_enable && request;
    assign complete = ZeroLat ? accept
                              : ((state_q == WAIT) && clock_enable && (count_q == LastCnt));

    // With no wait states the access completes at the acceptance edge, so it works
    // directly on the live inputs; otherwise it works on the captured request.
    assign opAddr  = ZeroLat ? address[AW-1:0] : addr_q;
    assign opSize  = ZeroLat ? size            : size_q;
    assign opSext  = ZeroLat ? sign_ext        : sext_q;
    assign opWrite = ZeroLat ? write           : isWrite_q;
    assign opWdata = ZeroLat ? write_data      : wdata_q;

    // Decide the effective size, the aligned first byte index and whether the access faults.
    always_comb begin
        effSize = opSize;
        idx0    = opAddr;
        fault   = 1'b0;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
        case (opSize)
            2'b01:   fault = opAddr[0];
            2'b10:   fault = (opAddr[1:0] != 2'b00);
            2'b11:   fault = 1'b1;
            default: fault = 1'b0;
        endcase
`else
        if (opSize == 2'b11) begin
            effSize = 2'b10;
        end
        if (effSize == 2'b01) begin
            idx0[0] = 1'b0;
        end else if (effSize == 2'b10) begin
            idx0[1:0] = 2'b00;
        end
`endif
    end

    assign idx1 = idx0 + AW'(1);
    assign idx2 = idx0 + AW'(2);
    assign idx3 = idx0 + AW'(3);

    assign b0 = mem_q[idx0];
    assign b1 = mem_q[idx1];
    assign b2 = mem_q[idx2];
    assign b3 = mem_q[idx3];

    // Assemble the big-endian load value, right-justified and sign- or zero-extended.
    always_comb begin
        loadValue = {b0, b1, b2, b3};
        case (effSize)
            2'b00:   loadValue = {{24{opSext & b0[7]}}, b0};
            2'b01:   loadValue = {{16{opSext & b0[7]}}, b0, b1};
            default: loadValue = {b0, b1, b2, b3};
        endcase
    end

    // A store lands only on a clean completion; a reset at that same edge discards it.
    assign commitStore = complete && opWrite && !fault && reset;

    // Memory array: big-endian byte lanes, no reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (commitStore) begin
            case (effSize)
                2'b00: begin
                    mem_q[idx0] <= opWdata[7:0];
                end
                2'b01: begin
                    mem_q[idx0] <= opWdata[15:8];
                    mem_q[idx1] <= opWdata[7:0];
                end
                default: begin
                    mem_q[idx0] <= opWdata[31:24];
                    mem_q[idx1] <= opWdata[23:16];
                    mem_q[idx2] <= opWdata[15:8];
                    mem_q[idx3] <= opWdata[7:0];
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: wait states are entered only when LATENCY is non-zero.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && !ZeroLat) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (complete) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture, wait counter and registered completion outputs; a stall freezes all but the pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q    <= 3'd0;
            addr_q     <= '0;
            size_q     <= 2'b00;
            sext_q     <= 1'b0;
            isWrite_q  <= 1'b0;
            wdata_q    <= 32'd0;
            readData_q <= 32'd0;
            ack_q      <= 1'b0;
            error_q    <= 1'b0;
        end else if (!clock_enable) begin
            ack_q   <= 1'b0;
            error_q <= 1'b0;
        end else begin
            ack_q   <= complete;
            error_q <= complete & fault;
            if (complete) begin
                if (fault) begin
                    readData_q <= 32'd0;
                end else if (!opWrite) begin
                    readData_q <= loadValue;
                end
            end
            if (accept) begin
                count_q   <= 3'd0;
                addr_q    <= address[AW-1:0];
                size_q    <= size;
                sext_q    <= sign_ext;
                isWrite_q <= write;
                wdata_q   <= write_data;
            end else if (state_q == WAIT) begin
                count_q <= count_q + 3'd1;
            end
        end
    end

    assign read_data   = readData_q;
    assign waitrequest = (state_q == WAIT);
    assign ack         = ack_q;
    assign error       = error_q;

endmodule

// File: tb/tb_data_mem_bank.sv
// tb_data_mem_bank: directed and randomized checks of data_mem_bank at
// LATENCY 1 (main instance, reference-model checked), LATENCY 0 and LATENCY 3.
module tb_data_mem_bank;

    localparam int Depth = 4096;

    logic        clk;
    logic        rstMain, rst3, ceMain, ce3;
    logic [31:0] address, writeData;
    logic [1:0]  size;
    logic        signExt;
    logic        rd0, wr0, rd1, wr1, rd3, wr3;
    logic [31:0] rdata0, rdata1, rdata3;
    logic        wait0, wait1, wait3;
    logic        ack0, ack1, ack3;
    logic        err0, err1, err3;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  model [Depth];
    logic [31:0] lastRd1 = 32'd0;

    data_mem_bank #(.DEPTH(Depth), .LATENCY(1)) dut1 (
        .clk(clk), .reset(rstMain), .clock_enable(ceMain), .address(address),
        .read(rd1), .write(wr1), .size(size), .sign_ext(signExt), .write_data(writeData),
        .read_data(rdata1), .waitrequest(wait1), .ack(ack1), .error(err1)
    );

    data_mem_bank #(.DEPTH(Depth), .LATENCY(0)) dut0 (
        .clk(clk), .reset(rstMain), .clock_enable(ceMain), .address(address),
        .read(rd0), .write(wr0), .size(size), .sign_ext(signExt), .write_data(writeData),
        .read_data(rdata0), .waitrequest(wait0), .ack(ack0), .error(err0)
    );

    data_mem_bank #(.DEPTH(Depth), .LATENCY(3)) dut3 (
        .clk(clk), .reset(rst3), .clock_enable(ce3), .address(address),
        .read(rd3), .write(wr3), .size(size), .sign_ext(signExt), .write_data(writeData),
        .read_data(rdata3), .waitrequest(wait3), .ack(ack3), .error(err3)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference model: accesses described as byte counts and byte-wise arithmetic.
    function automatic int accBytes(input logic [1:0] sz);
        return (sz == 2'd3) ? 4 : (1 << sz);
    endfunction

    function automatic bit modelFault(input logic [31:0] addr, input logic [1:0] sz);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
        return (sz == 2'd3) || ((addr % accBytes(sz)) != 0);
`else
        return (accBytes(sz) == 0) && (addr == 32'd0);
`endif
    endfunction

    function automatic int baseIdx(input logic [31:0] addr, input logic [1:0] sz);
        int n;
        logic [31:0] a;
        n = accBytes(sz);
        a = addr - (addr % n);
        return int'(a % Depth);
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] addr, input logic [1:0] sz, input bit sx);
        int n;
        int base;
        logic [31:0] v;
        n = accBytes(sz);
        base = baseIdx(addr, sz);
        v = 32'd0;
        for (int i = 0; i < n; i++) begin
            v = (v << 8) | {24'd0, model[(base + i) % Depth]};
        end
        if (sx && n < 4 && v[8*n-1]) begin
            v = v | ~((32'd1 << (8 * n)) - 32'd1);
        end
        return v;
    endfunction

    task automatic modelStore(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] wd);
        int n;
        int base;
        logic [31:0] shifted;
        n = accBytes(sz);
        base = baseIdx(addr, sz);
        for (int i = 0; i < n; i++) begin
            shifted = wd >> (8 * (n - 1 - i));
            model[(base + i) % Depth] = shifted[7:0];
        end
    endtask

    // One full access on the LATENCY=1 instance, checked against the model.
    task automatic applyStimulus(input bit isWr, input logic [31:0] addr, input logic [1:0] sz,
                                 input bit sx, input logic [31:0] wd);
        int waits;
        int n;
        bit flt;
        logic [31:0] expRd;
        flt = modelFault(addr, sz);
        if (flt) begin
            expRd = 32'd0;
        end else if (isWr) begin
            modelStore(addr, sz, wd);
            expRd = lastRd1;
        end else begin
            expRd = modelLoad(addr, sz, sx);
        end
        address   = addr;
        size      = sz;
        signExt   = sx;
        writeData = wd;
        wr1       = isWr;
        rd1       = isWr ? 1'($urandom_range(0, 1)) : 1'b1;
        tick();
        address   = $urandom;
        writeData = $urandom;
        size      = 2'($urandom_range(0, 3));
        rd1       = 1'($urandom_range(0, 1));
        wr1       = 1'($urandom_range(0, 1));
        checkOutput("ackPulseEnd", {31'd0, ack1}, 32'd0);
        waits = 0;
        n = 0;
        while (ack1 !== 1'b1 && n < 20) begin
            if (wait1 === 1'b1) waits++;
            tick();
            n++;
        end
        rd1 = 1'b0;
        wr1 = 1'b0;
        checkOutput("ackSeen", {31'd0, ack1}, 32'd1);
        checkOutput("waitCycles", waits, 32'd1);
        checkOutput("error", {31'd0, err1}, {31'd0, flt});
        checkOutput("readData", rdata1, expRd);
        lastRd1 = expRd;
    endtask

    // One word access on the LATENCY=3 instance with an optional stall right after acceptance.
    task automatic access3(input bit isWr, input logic [31:0] addr, input logic [31:0] wd,
                           input int hold, output int ticks);
        address   = addr;
        size      = 2'd2;
        signExt   = 1'b0;
        writeData = wd;
        rd3       = !isWr;
        wr3       = isWr;
        tick();
        rd3   = 1'b0;
        wr3   = 1'b0;
        ticks = 0;
        if (hold > 0) begin
            ce3 = 1'b0;
            repeat (hold) begin
                tick();
                ticks++;
                checkOutput("lat3FrozenWait", {31'd0, wait3}, 32'd1);
                checkOutput("lat3FrozenAck", {31'd0, ack3}, 32'd0);
            end
            ce3 = 1'b1;
        end
        while (ack3 !== 1'b1 && ticks < 30) begin
            tick();
            ticks++;
        end
    endtask

    initial begin
        int t;
        logic ackAny;
        rstMain = 1'b0; rst3 = 1'b0; ceMain = 1'b1; ce3 = 1'b1;
        address = 32'd0; writeData = 32'd0; size = 2'd0; signExt = 1'b0;
        rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0; rd3 = 1'b0; wr3 = 1'b0;
        tick();
        tick();
        checkOutput("rstReadData", rdata1, 32'd0);
        checkOutput("rstWait", {31'd0, wait1}, 32'd0);
        checkOutput("rstAck", {31'd0, ack1}, 32'd0);
        checkOutput("rstError", {31'd0, err1}, 32'd0);
        checkOutput("rstReadData3", rdata3, 32'd0);
        rstMain = 1'b1;
        rst3    = 1'b1;
        tick();

        // Give the low 64 bytes defined contents.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 32'(4 * i), 2'd2, 1'b0, $urandom);
        end

        applyStimulus(1'b1, 32'h10, 2'd2, 1'b0, 32'h11223344);
        applyStimulus(1'b0, 32'h10, 2'd2, 1'b0, 32'd0);
        checkOutput("wordRead", rdata1, 32'h11223344);
        applyStimulus(1'b0, 32'h11, 2'd0, 1'b0, 32'd0);
        checkOutput("byteRead", rdata1, 32'h00000022);

        applyStimulus(1'b1, 32'h20, 2'd0, 1'b0, 32'h00000080);
        applyStimulus(1'b0, 32'h20, 2'd0, 1'b1, 32'd0);
        checkOutput("byteSext", rdata1, 32'hFFFFFF80);
        applyStimulus(1'b0, 32'h20, 2'd0, 1'b0, 32'd0);
        checkOutput("byteZext", rdata1, 32'h00000080);
        applyStimulus(1'b0, 32'h20, 2'd1, 1'b1, 32'd0);
        checkOutput("halfSext", rdata1, {16'hFFFF, 8'h80, model[32'h21]});

        applyStimulus(1'b1, 32'(Depth + 4), 2'd2, 1'b0, 32'hCAFEBABE);
        applyStimulus(1'b0, 32'h4, 2'd2, 1'b0, 32'd0);
        checkOutput("wrapRead", rdata1, 32'hCAFEBABE);
        applyStimulus(1'b0, 32'h6, 2'd2, 1'b0, 32'd0);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
        checkOutput("misalignRead", rdata1, 32'd0);
`else
        checkOutput("misalignRead", rdata1, 32'hCAFEBABE);
`endif

        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)),
                          32'($urandom_range(0, 63)) + 32'($urandom_range(0, 3) * Depth),
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
        end

        // LATENCY=0: back-to-back writes then reads, one completion per cycle.
        size = 2'd2;
        signExt = 1'b0;
        wr0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            address   = 32'(4 * i);
            writeData = 32'hA0000000 + 32'(i);
            tick();
            checkOutput("lat0WrAck", {31'd0, ack0}, 32'd1);
            checkOutput("lat0WrWait", {31'd0, wait0}, 32'd0);
        end
        wr0 = 1'b0;
        rd0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            address = 32'(4 * i);
            tick();
            checkOutput("lat0RdAck", {31'd0, ack0}, 32'd1);
            checkOutput("lat0RdWait", {31'd0, wait0}, 32'd0);
            checkOutput("lat0RdData", rdata0, 32'hA0000000 + 32'(i));
        end
        rd0 = 1'b0;
        tick();
        checkOutput("lat0IdleAck", {31'd0, ack0}, 32'd0);

        // LATENCY=3: normal write, write killed by reset, then reads with and without a stall.
        access3(1'b1, 32'h40, 32'hAAAA5555, 0, t);
        checkOutput("lat3WrTicks", t, 32'd3);
        address   = 32'h40;
        writeData = 32'h12345678;
        wr3 = 1'b1;
        tick();
        wr3 = 1'b0;
        checkOutput("lat3Pending", {31'd0, wait3}, 32'd1);
        rst3 = 1'b0;
        tick();
        rst3 = 1'b1;
        checkOutput("lat3RstWait", {31'd0, wait3}, 32'd0);
        ackAny = ack3;
        repeat (5) begin
            tick();
            ackAny = ackAny | ack3;
        end
        checkOutput("lat3RstNoAck", {31'd0, ackAny}, 32'd0);
        access3(1'b0, 32'h40, 32'd0, 0, t);
        checkOutput("lat3RdTicks", t, 32'd3);
        checkOutput("lat3OldData", rdata3, 32'hAAAA5555);
        access3(1'b0, 32'h40, 32'd0, 2, t);
        checkOutput("lat3StallTicks", t, 32'd5);
        checkOutput("lat3StallData", rdata3, 32'hAAAA5555);
        tick();
        checkOutput("lat3AckPulse", {31'd0, ack3}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
